// File: rtl/idp_pipe_if.sv
// Issue/result bundle between the control unit (master) and the idp_pipe data path (slave).
interface idp_pipe_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              stall;
    logic              W_En;
    logic [ADDR_W-1:0] W_Adr;
    logic [ADDR_W-1:0] R_Adr;
    logic [ADDR_W-1:0] S_Adr;
    logic              S_Sel;
    logic [WIDTH-1:0]  DS;
    logic [3:0]        ALU_OP;
    logic              out_valid;
    logic [WIDTH-1:0]  Reg_Out;
    logic [WIDTH-1:0]  Alu_Out;
    logic              C;
    logic              N;
    logic              Z;

    modport master (
        output in_valid, stall, W_En, W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP,
        input  out_valid, Reg_Out, Alu_Out, C, N, Z
    );

    modport slave (
        input  in_valid, stall, W_En, W_Adr, R_Adr, S_Adr, S_Sel, DS, ALU_OP,
        output out_valid, Reg_Out, Alu_Out, C, N, Z
    );
endinterface

// File: rtl/idp_pipe.sv
// Two-stage integer data path: issue (RF read / operand select) then EX (ALU, flags, write-back),
// with EX-to-issue forwarding so dependent micro-ops can issue back to back.
module idp_pipe #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3,
    parameter int FWD_EN = 1
) (
    input logic        clk,
    input logic        reset,
    idp_pipe_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        OP_PASS_S = 4'd0,  OP_PASS_R = 4'd1,  OP_ADD = 4'd2,  OP_SUB = 4'd3,
        OP_INC    = 4'd4,  OP_DEC    = 4'd5,  OP_SHL = 4'd6,  OP_SHR = 4'd7,
        OP_ASR    = 4'd8,  OP_AND    = 4'd9,  OP_OR  = 4'd10, OP_XOR = 4'd11,
        OP_NOT    = 4'd12, OP_NEG    = 4'd13, OP_CLR = 4'd14, OP_SET = 4'd15
    } alu_op_e;

    logic [WIDTH-1:0]  r_rf [DEPTH];

    logic              r_ex_valid;
    logic [WIDTH-1:0]  r_ex_r;
    logic [WIDTH-1:0]  r_ex_s;
    alu_op_e           r_ex_op;
    logic              r_ex_wen;
    logic [ADDR_W-1:0] r_ex_wadr;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_reg_out;
    logic [WIDTH-1:0]  r_alu_out;
    logic              r_c;
    logic              r_n;
    logic              r_z;

    logic [WIDTH:0]    w_sum;
    logic [WIDTH-1:0]  w_res;
    logic              w_c;
    logic              w_fwd_r;
    logic              w_fwd_s;
    logic [WIDTH-1:0]  w_op_r;
    logic [WIDTH-1:0]  w_op_s;

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        unique case (r_ex_op)
            OP_PASS_S: w_res = r_ex_s;
            OP_PASS_R: w_res = r_ex_r;
            OP_ADD: begin
                w_sum = {1'b0, r_ex_r} + {1'b0, r_ex_s};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_sum = {1'b0, r_ex_r} + {1'b0, ~r_ex_s} + (WIDTH+1)'(1);
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            OP_INC: begin
                w_sum = {1'b0, r_ex_s} + (WIDTH+1)'(1);
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
            end
            OP_DEC: begin
                w_res = r_ex_s - WIDTH'(1);
                w_c   = |r_ex_s;
            end
            OP_SHL: begin
                w_res = {r_ex_s[WIDTH-2:0], 1'b0};
                w_c   = r_ex_s[WIDTH-1];
            end
            OP_SHR: begin
                w_res = {1'b0, r_ex_s[WIDTH-1:1]};
                w_c   = r_ex_s[0];
            end
            OP_ASR: begin
                w_res = {r_ex_s[WIDTH-1], r_ex_s[WIDTH-1:1]};
                w_c   = r_ex_s[0];
            end
            OP_AND: w_res = r_ex_r & r_ex_s;
            OP_OR:  w_res = r_ex_r | r_ex_s;
            OP_XOR: w_res = r_ex_r ^ r_ex_s;
            OP_NOT: w_res = ~r_ex_s;
            OP_NEG: begin
                w_res = ~r_ex_s + WIDTH'(1);
                w_c   = |r_ex_s;
            end
            OP_CLR: w_res = '0;
            OP_SET: w_res = '1;
            default: w_res = '0;
        endcase
    end

    // The EX result is written to the RF on the same edge this issue reads it, so bypass it here.
    always_comb begin
        w_fwd_r = (FWD_EN != 0) && r_ex_valid && r_ex_wen && (r_ex_wadr == bus.R_Adr);
        w_fwd_s = (FWD_EN != 0) && r_ex_valid && r_ex_wen && (r_ex_wadr == bus.S_Adr);
        w_op_r  = w_fwd_r ? w_res : r_rf[bus.R_Adr];
        if (bus.S_Sel) begin
            w_op_s = bus.DS;
        end else begin
            w_op_s = w_fwd_s ? w_res : r_rf[bus.S_Adr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_rf[i] <= '0;
            end
            r_ex_valid  <= 1'b0;
            r_ex_r      <= '0;
            r_ex_s      <= '0;
            r_ex_op     <= OP_PASS_S;
            r_ex_wen    <= 1'b0;
            r_ex_wadr   <= '0;
            r_out_valid <= 1'b0;
            r_reg_out   <= '0;
            r_alu_out   <= '0;
            r_c         <= 1'b0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
        end else if (!bus.stall) begin
            r_ex_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_ex_r    <= w_op_r;
                r_ex_s    <= w_op_s;
                r_ex_op   <= alu_op_e'(bus.ALU_OP);
                r_ex_wen  <= bus.W_En;
                r_ex_wadr <= bus.W_Adr;
            end
            r_out_valid <= r_ex_valid;
            if (r_ex_valid) begin
                r_alu_out <= w_res;
                r_reg_out <= r_ex_r;
                r_c       <= w_c;
                r_n       <= w_res[WIDTH-1];
                r_z       <= (w_res == '0);
                if (r_ex_wen) begin
                    r_rf[r_ex_wadr] <= w_res;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.Reg_Out   = r_reg_out;
    assign bus.Alu_Out   = r_alu_out;
    assign bus.C         = r_c;
    assign bus.N         = r_n;
    assign bus.Z         = r_z;
endmodule

// File: tb/tb_idp_pipe.sv
// Scoreboard bench for idp_pipe: a 16-bit forwarding instance under random traffic against a
// sequential-execution reference, plus an 8-bit non-forwarding instance with directed expectations.
module tb_idp_pipe;
    localparam int W1 = 16;
    localparam int A1 = 3;
    localparam int W2 = 8;
    localparam int A2 = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    idp_pipe_if #(.WIDTH(W1), .ADDR_W(A1)) bus1 ();
    idp_pipe_if #(.WIDTH(W2), .ADDR_W(A2)) bus2 ();

    idp_pipe #(.WIDTH(W1), .ADDR_W(A1), .FWD_EN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    idp_pipe #(.WIDTH(W2), .ADDR_W(A2), .FWD_EN(0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    typedef struct {
        int unsigned idx;
        int unsigned alu;
        int unsigned rg;
        int unsigned cnz;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e1;
    exp_t        e2;
    int          tests = 0;
    int          fails = 0;
    int unsigned ecnt1 = 0;
    int unsigned ecnt2 = 0;
    bit          fresh1 = 1'b0;
    bit          fresh2 = 1'b0;
    int unsigned m_rf[8];

    task automatic check(input string name, input int unsigned act, input int unsigned expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Sequential-semantics reference: result and carry from plain modular arithmetic.
    function automatic void alu_ref(input int w, input int unsigned op, input int unsigned r,
                                    input int unsigned s, output int unsigned res, output bit c);
        int unsigned m   = (32'd1 << w) - 1;
        int unsigned msb = 32'd1 << (w - 1);
        c = 1'b0;
        case (op)
            0:  res = s;
            1:  res = r;
            2:  begin res = (r + s) & m; c = (r + s) > m; end
            3:  begin res = (r - s) & m; c = (r >= s); end
            4:  begin res = (s + 1) & m; c = (s == m); end
            5:  begin res = (s - 1) & m; c = (s != 0); end
            6:  begin res = (s << 1) & m; c = (s & msb) != 0; end
            7:  begin res = s >> 1; c = (s & 1) != 0; end
            8:  begin res = (s >> 1) | (s & msb); c = (s & 1) != 0; end
            9:  res = r & s;
            10: res = r | s;
            11: res = r ^ s;
            12: res = ~s & m;
            13: begin res = (0 - s) & m; c = (s != 0); end
            14: res = 0;
            default: res = m;
        endcase
    endfunction

    always @(posedge clk) begin
        fresh1 = reset && !bus1.stall;
        fresh2 = reset && !bus2.stall;
        if (fresh1) ecnt1++;
        if (fresh2) ecnt2++;
    end

    // An op accepted at advancing edge k must be presented right after advancing edge k+1.
    always @(negedge clk) begin
        if (fresh1) begin
            if (q1.size() > 0 && q1[0].idx + 1 == ecnt1) begin
                e1 = q1.pop_front();
                check("d1 out_valid", bus1.out_valid, 1);
                check("d1 Alu_Out", bus1.Alu_Out, e1.alu);
                check("d1 Reg_Out", bus1.Reg_Out, e1.rg);
                check("d1 CNZ", {bus1.C, bus1.N, bus1.Z}, e1.cnz);
            end else begin
                check("d1 idle out_valid", bus1.out_valid, 0);
            end
        end
        if (fresh2) begin
            if (q2.size() > 0 && q2[0].idx + 1 == ecnt2) begin
                e2 = q2.pop_front();
                check("d2 out_valid", bus2.out_valid, 1);
                check("d2 Alu_Out", bus2.Alu_Out, e2.alu);
                check("d2 Reg_Out", bus2.Reg_Out, e2.rg);
                check("d2 CNZ", {bus2.C, bus2.N, bus2.Z}, e2.cnz);
            end else begin
                check("d2 idle out_valid", bus2.out_valid, 0);
            end
        end
    end

    task automatic drive1(input bit v, input bit st, input bit we, input int unsigned wa,
                          input int unsigned ra, input int unsigned sa, input bit ssel,
                          input int unsigned ds, input int unsigned op);
        int unsigned r, s, res;
        bit          c;
        exp_t        e;
        bus1.in_valid = v;
        bus1.stall    = st;
        bus1.W_En     = we;
        bus1.W_Adr    = A1'(wa);
        bus1.R_Adr    = A1'(ra);
        bus1.S_Adr    = A1'(sa);
        bus1.S_Sel    = ssel;
        bus1.DS       = W1'(ds);
        bus1.ALU_OP   = 4'(op);
        @(posedge clk);
        #1;
        if (v && !st) begin
            r = m_rf[ra & 7];
            s = ssel ? (ds & 16'hFFFF) : m_rf[sa & 7];
            alu_ref(W1, op & 15, r, s, res, c);
            if (we) m_rf[wa & 7] = res;
            e.idx = ecnt1;
            e.alu = res;
            e.rg  = r;
            e.cnz = {29'd0, c, res[15], res == 0};
            q1.push_back(e);
        end
    endtask

    task automatic drive2(input bit v, input bit we, input int unsigned wa, input int unsigned ra,
                          input int unsigned sa, input bit ssel, input int unsigned ds,
                          input int unsigned op, input int unsigned ealu, input int unsigned erg,
                          input int unsigned ecnz);
        exp_t e;
        bus2.in_valid = v;
        bus2.stall    = 1'b0;
        bus2.W_En     = we;
        bus2.W_Adr    = A2'(wa);
        bus2.R_Adr    = A2'(ra);
        bus2.S_Adr    = A2'(sa);
        bus2.S_Sel    = ssel;
        bus2.DS       = W2'(ds);
        bus2.ALU_OP   = 4'(op);
        @(posedge clk);
        #1;
        if (v) begin
            e.idx = ecnt2;
            e.alu = ealu;
            e.rg  = erg;
            e.cnz = ecnz;
            q2.push_back(e);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " d1 out_valid"}, bus1.out_valid, 0);
        check({tag, " d1 Alu_Out"}, bus1.Alu_Out, 0);
        check({tag, " d1 Reg_Out"}, bus1.Reg_Out, 0);
        check({tag, " d1 CNZ"}, {bus1.C, bus1.N, bus1.Z}, 0);
        check({tag, " d2 out_valid"}, bus2.out_valid, 0);
    endtask

    initial begin
        reset = 1'b0;
        foreach (m_rf[i]) m_rf[i] = 0;
        drive2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_reset_outputs("por");
        reset = 1'b1;

        // Load / add: RF[3] = 0x1234 + 0x0001, then read RF[3] back.
        drive1(1, 0, 1, 1, 0, 0, 1, 'h1234, 0);
        drive1(1, 0, 1, 2, 0, 0, 1, 'h0001, 0);
        drive1(1, 0, 1, 3, 1, 2, 0, 0, 2);
        drive1(1, 0, 0, 0, 3, 0, 0, 0, 1);

        // Back-to-back dependent increments from 0xFFFF.
        drive1(1, 0, 1, 1, 0, 0, 1, 'hFFFF, 0);
        repeat (3) drive1(1, 0, 1, 1, 1, 1, 0, 0, 4);

        // Subtract both directions, including a borrow.
        drive1(1, 0, 1, 4, 0, 0, 1, 3, 0);
        drive1(1, 0, 1, 5, 0, 0, 1, 5, 0);
        drive1(1, 0, 0, 0, 4, 5, 0, 0, 3);
        drive1(1, 0, 0, 0, 5, 4, 0, 0, 3);
        drive1(1, 0, 0, 0, 4, 0, 1, 5, 3);

        // Stall with an op sitting in EX: outputs must hold the previous result.
        drive1(1, 0, 0, 0, 0, 0, 0, 0, 15);
        drive1(1, 0, 1, 6, 0, 0, 1, 'h00AA, 0);
        repeat (3) drive1(1, 1, 0, 0, 6, 0, 0, 0, 1);
        check("stall held Alu_Out", bus1.Alu_Out, 'hFFFF);
        check("stall held out_valid", bus1.out_valid, 1);
        drive1(1, 0, 0, 0, 6, 0, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                reset = 1'b0;
                q1.delete();
                foreach (m_rf[k]) m_rf[k] = 0;
                #1;
                check_reset_outputs("midrun");
                bus1.in_valid = 1'b0;
                bus1.stall    = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b1;
                drive1(1, 0, 0, 0, 5, 5, 0, 0, 1);
            end
            drive1($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1) == 1, $urandom & 16'hFFFF, $urandom_range(0, 15));
        end
        drive1(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 8-bit, 16-entry, no forwarding: shift-out carry, RF[15] read-back, stale dependent read.
        drive2(1, 1, 15, 0, 0, 1, 'h80, 0, 'h80, 0, 3'b010);
        drive2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive2(1, 1, 14, 15, 15, 0, 0, 6, 'h00, 'h80, 3'b101);
        drive2(1, 0, 0, 15, 0, 0, 0, 1, 'h80, 'h80, 3'b010);
        drive2(1, 1, 1, 0, 0, 1, 'hFF, 0, 'hFF, 0, 3'b010);
        drive2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive2(1, 1, 1, 0, 1, 0, 0, 4, 'h00, 0, 3'b101);
        drive2(1, 1, 1, 0, 1, 0, 0, 4, 'h00, 0, 3'b101);
        drive2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive2(1, 0, 0, 1, 0, 0, 0, 1, 'h00, 'h00, 3'b001);
        drive2(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && (q1.size() + q2.size()) != 0; i++) @(posedge clk);
        #1;
        check("drain q1", q1.size(), 0);
        check("drain q2", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/idp_pipe.md
Name: idp_pipe

Overview:
- Parametrised, two-stage pipelined integer data path. Successor to the 16-bit, 8-register single-cycle IDP.
- Integrates a DEPTH-entry register file, an S-operand mux (register or external DS), an ALU with registered status flags, and write-back.
- Adds a valid/stall handshake and one-level result forwarding so back-to-back dependent operations issue without bubbles.
- Sits between the control unit (issues one micro-op per cycle) and memory/IO (consumes Alu_Out/Reg_Out).

Parameters:
- WIDTH, 16, data path width in bits (min 4).
- ADDR_W, 3, register address width; DEPTH = 2**ADDR_W registers.
- FWD_EN, 1, 1 = EX-to-issue forwarding enabled; 0 = no forwarding (raw RF read; hazards are the software's responsibility).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  micro-op present on issue inputs this cycle
- stall  in  1  freeze both pipeline stages and register file
- W_En  in  1  write ALU result to RF at W_Adr
- W_Adr  in  ADDR_W  write-back address
- R_Adr  in  ADDR_W  R operand address
- S_Adr  in  ADDR_W  S operand address
- S_Sel  in  1  1 = S operand from DS, 0 = RF[S_Adr]
- DS  in  WIDTH  external data in
- ALU_OP  in  4  operation code
- out_valid  out  1  Alu_Out/Reg_Out/flags hold a completed op
- Reg_Out  out  WIDTH  registered R operand of completed op
- Alu_Out  out  WIDTH  registered ALU result
- C, N, Z  out  1 each  registered carry, negative, zero flags

Behaviour:
- Reset (reset=0, async): all RF entries, pipeline registers, Reg_Out, Alu_Out, C, N, Z and out_valid = 0. Reset wins over stall and in_valid.
- Stage 1 (issue edge): when in_valid & !stall, capture R = RF[R_Adr], S = S_Sel ? DS : RF[S_Adr], plus ALU_OP, W_En, W_Adr into the EX register; ex_valid <= 1. When !in_valid & !stall: ex_valid <= 0.
- Stage 2 (EX edge): when ex_valid & !stall:
  - ALU result -> Alu_Out; R -> Reg_Out; flags updated; out_valid <= 1.
  - If W_En, RF[W_Adr] <= result on the same edge.
  - When !ex_valid & !stall: out_valid <= 0; Alu_Out, Reg_Out and flags hold.
- Latency: op issued at edge n appears at edge n+1 on outputs (out_valid high the cycle after the EX edge); throughput 1 op/cycle.
- Forwarding (FWD_EN=1): at issue, if ex_valid & ex W_En & ex W_Adr == R_Adr, R takes the EX-stage ALU result instead of RF; same for S when S_Sel=0. An RF write on the same edge is thus never missed. Forwarding is suppressed when S_Sel=1.
- stall=1: no register changes at all (RF, EX, outputs); in_valid is ignored that cycle, so the issuer must hold the op.
- ALU ops (mod 2**WIDTH; C=0 unless stated):
  - 0 pass S; 1 pass R.
  - 2 R+S, C = carry out.
  - 3 R-S computed as R+~S+1, C = carry out (1 = no borrow).
  - 4 S+1, C = carry out; 5 S-1, C = 1 unless S==0.
  - 6 S<<1, C = S[MSB]; 7 S>>1 logical, C = S[0]; 8 S>>>1 arithmetic, C = S[0].
  - 9 R&S; 10 R|S; 11 R^S; 12 ~S.
  - 13 -S, C = 1 iff S != 0.
  - 14 0 (clear); 15 all ones.
- N = result[WIDTH-1]; Z = (result == 0); both for every op.
- Same W_Adr written by consecutive ops: the later op wins. A write and a read of the same address in the same cycle, outside forwarding, returns the old value.

Test Plan:
- Reset: drive reset=0 mid-run with ops in flight -> out_valid=0, Alu_Out=0, flags=0 immediately; after release, RF[5] reads 0.
- Load/add: issue op0 DS=0x1234 S_Sel=1 W_En W_Adr=1; then op0 DS=0x0001 W_Adr=2; then op2 R=1 S=2 W_Adr=3 -> Alu_Out=0x1235, C=0, N=0, Z=0; RF[3]=0x1235.
- Forwarding: back-to-back op4 on R1/S1 from 0xFFFF, three times, no bubbles -> outputs 0x0000 (C=1, Z=1), then 0x0001, then 0x0002; with FWD_EN=0 the second op returns stale 0x0000 (S=0xFFFF+1 wraps).
- Subtract: R=0x0003, S=0x0005, op3 -> Alu_Out=0xFFFE, C=0, N=1; R=5, S=3 -> 0x0002, C=1.
- Stall: assert stall for 3 cycles with ex_valid=1 -> Alu_Out, out_valid and RF unchanged; result appears one cycle after stall drops.
- Width sweep: WIDTH=8, ADDR_W=4; op6 on S=0x80 -> Alu_Out=0x00, C=1, Z=1; write and read back RF[15].
